// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit: stall vector layout,
// per-source stall masks, FSM state encoding and the zero word.
package pipe_ctrl_pkg;

    localparam int STALL_W = 6;

    // Each source holds its own stage and every earlier one.
    localparam logic [STALL_W-1:0] STALL_MASK_ID  = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_MASK_EX  = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MASK_MEM = 6'b011111;
    localparam logic [STALL_W-1:0] STALL_NONE     = 6'b000000;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MC_WAIT = 2'd1,
        ST_FLUSH   = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with multi-cycle EX sequencing and watchdog.
// Optional perf counters are enabled with the PIPE_CTRL_PERF_EN macro.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MC_MAX_CYCLES = 32,
    parameter int CNT_W         = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_id_i,
    input  logic               stallreq_mem_i,
    input  logic               mc_start_i,
    input  logic               mc_done_i,
    input  logic               redirect_i,
    input  logic [31:0]        redirect_pc_i,
    output logic [STALL_W-1:0] stall_o,
    output logic               flush_o,
    output logic [31:0]        new_pc_o,
    output logic               mc_busy_o,
    output logic               mc_abort_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]        stall_cycles_o,
    output logic [31:0]        flush_count_o
`endif
);

    pipe_state_t      state;
    logic [CNT_W-1:0] mc_cnt;
    logic             mc_expire;
    logic             mc_stall;
    logic [STALL_W-1:0] stall_raw;

    assign mc_expire = (state == ST_MC_WAIT) && (mc_cnt == CNT_W'(MC_MAX_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            mc_cnt    <= '0;
            new_pc_o  <= ZERO_WORD;
            flush_o   <= 1'b0;
            mc_busy_o <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (redirect_i) begin
                        state    <= ST_FLUSH;
                        new_pc_o <= redirect_pc_i;
                        flush_o  <= 1'b1;
                    end else if (mc_start_i) begin
                        state     <= ST_MC_WAIT;
                        mc_cnt    <= '0;
                        mc_busy_o <= 1'b1;
                    end
                end
                ST_MC_WAIT: begin
                    mc_cnt <= mc_cnt + 1'b1;
                    if (mc_done_i || mc_expire) begin
                        state     <= ST_IDLE;
                        mc_busy_o <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    state   <= ST_IDLE;
                    flush_o <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    flush_o   <= 1'b0;
                    mc_busy_o <= 1'b0;
                end
            endcase
        end
    end

    // Releasing the EX hold on expiry lets the aborted op drain in the same cycle.
    assign mc_stall = ((state == ST_IDLE) && mc_start_i && !redirect_i) ||
                      ((state == ST_MC_WAIT) && !mc_done_i && !mc_expire);

    always_comb begin
        stall_raw = STALL_NONE;
        if (stallreq_id_i)  stall_raw = stall_raw | STALL_MASK_ID;
        if (mc_stall)       stall_raw = stall_raw | STALL_MASK_EX;
        if (stallreq_mem_i) stall_raw = stall_raw | STALL_MASK_MEM;
    end

    always_comb begin
        stall_o = STALL_NONE;
        if (!rst) begin
            if (state == ST_FLUSH)
                stall_o = stallreq_mem_i ? STALL_MASK_MEM : STALL_NONE;
            else
                stall_o = stall_raw;
        end
    end

    assign mc_abort_o = !rst && mc_expire && !mc_done_i;

`ifdef PIPE_CTRL_PERF_EN
    localparam int ID_BIT = 2;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_o <= ZERO_WORD;
            flush_count_o  <= ZERO_WORD;
        end else begin
            if (stall_o[ID_BIT] && (stall_cycles_o != 32'hFFFF_FFFF))
                stall_cycles_o <= stall_cycles_o + 32'd1;
            if (flush_o && (flush_count_o != 32'hFFFF_FFFF))
                flush_count_o <= flush_count_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl with an 8-cycle watchdog.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_id_i, stallreq_mem_i, mc_start_i, mc_done_i, redirect_i;
    logic [31:0] redirect_pc_i;
    logic [5:0]  stall_o;
    logic        flush_o, mc_busy_o, mc_abort_o;
    logic [31:0] new_pc_o;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles_o, flush_count_o;
`endif

    int total = 0;
    int bad   = 0;

    pipe_ctrl #(.MC_MAX_CYCLES(8), .CNT_W(6)) dut (
        .clk            (clk),
        .rst            (rst),
        .stallreq_id_i  (stallreq_id_i),
        .stallreq_mem_i (stallreq_mem_i),
        .mc_start_i     (mc_start_i),
        .mc_done_i      (mc_done_i),
        .redirect_i     (redirect_i),
        .redirect_pc_i  (redirect_pc_i),
        .stall_o        (stall_o),
        .flush_o        (flush_o),
        .new_pc_o       (new_pc_o),
        .mc_busy_o      (mc_busy_o),
        .mc_abort_o     (mc_abort_o)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .stall_cycles_o (stall_cycles_o),
        .flush_count_o  (flush_count_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       id;
        logic       mem;
        logic [5:0] exp_stall;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1ns later.
    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{id: 1'b0, mem: 1'b0, exp_stall: 6'b000000};
        vecs[1] = '{id: 1'b1, mem: 1'b0, exp_stall: 6'b000111};
        vecs[2] = '{id: 1'b0, mem: 1'b1, exp_stall: 6'b011111};
        vecs[3] = '{id: 1'b1, mem: 1'b1, exp_stall: 6'b011111};

        rst = 1'b1;
        stallreq_id_i = 0; stallreq_mem_i = 0; mc_start_i = 0; mc_done_i = 0;
        redirect_i = 0; redirect_pc_i = 32'h0;
        tick(); tick(); #1;
        chk("rst_stall", 32'(stall_o), 32'h0);
        chk("rst_flush", 32'(flush_o), 32'h0);
        chk("rst_new_pc", new_pc_o, 32'h0);
        chk("rst_busy", 32'(mc_busy_o), 32'h0);
        chk("rst_abort", 32'(mc_abort_o), 32'h0);
        tick(); rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            tick();
            stallreq_id_i = vecs[i].id; stallreq_mem_i = vecs[i].mem;
            #1;
            chk($sformatf("vec%0d_stall", i), 32'(stall_o), 32'(vecs[i].exp_stall));
            chk($sformatf("vec%0d_busy", i), 32'(mc_busy_o), 32'h0);
        end
        tick(); stallreq_id_i = 0; stallreq_mem_i = 0;

        // Redirect; a redirect and a start arriving during FLUSH are ignored.
        tick(); redirect_i = 1; redirect_pc_i = 32'h1C00_0100; #1;
        chk("redir_n_stall", 32'(stall_o), 32'h0);
        chk("redir_n_flush", 32'(flush_o), 32'h0);
        tick(); redirect_pc_i = 32'hDEAD_BEEF; mc_start_i = 1; #1;
        chk("redir_n1_flush", 32'(flush_o), 32'h1);
        chk("redir_n1_pc", new_pc_o, 32'h1C00_0100);
        chk("redir_n1_stall", 32'(stall_o), 32'h0);
        tick(); redirect_i = 0; mc_start_i = 0; #1;
        chk("redir_n2_flush", 32'(flush_o), 32'h0);
        chk("redir_n2_busy", 32'(mc_busy_o), 32'h0);
        chk("redir_n2_pc", new_pc_o, 32'h1C00_0100);

        // Multi-cycle op with done at N+5.
        tick(); mc_start_i = 1; #1;
        chk("mc_n_stall", 32'(stall_o), 32'h0F);
        chk("mc_n_busy", 32'(mc_busy_o), 32'h0);
        for (int k = 1; k <= 4; k++) begin
            tick(); mc_start_i = 0; #1;
            chk($sformatf("mc_n%0d_stall", k), 32'(stall_o), 32'h0F);
            chk($sformatf("mc_n%0d_busy", k), 32'(mc_busy_o), 32'h1);
        end
        tick(); mc_done_i = 1; #1;
        chk("mc_done_stall", 32'(stall_o), 32'h0);
        chk("mc_done_busy", 32'(mc_busy_o), 32'h1);
        chk("mc_done_abort", 32'(mc_abort_o), 32'h0);
        tick(); mc_done_i = 0; #1;
        chk("mc_after_busy", 32'(mc_busy_o), 32'h0);
        chk("mc_after_stall", 32'(stall_o), 32'h0);

        // Watchdog expiry with no done.
        tick(); mc_start_i = 1;
        for (int k = 1; k <= 7; k++) begin
            tick(); mc_start_i = 0; #1;
            chk($sformatf("wd_n%0d_abort", k), 32'(mc_abort_o), 32'h0);
            chk($sformatf("wd_n%0d_stall", k), 32'(stall_o), 32'h0F);
        end
        tick(); #1;
        chk("wd_abort", 32'(mc_abort_o), 32'h1);
        chk("wd_abort_stall", 32'(stall_o), 32'h0);
        chk("wd_abort_busy", 32'(mc_busy_o), 32'h1);
        tick(); #1;
        chk("wd_after_abort", 32'(mc_abort_o), 32'h0);
        chk("wd_after_busy", 32'(mc_busy_o), 32'h0);

        // Done coincides with expiry: done wins.
        tick(); mc_start_i = 1;
        for (int k = 1; k <= 7; k++) begin
            tick(); mc_start_i = 0;
        end
        tick(); mc_done_i = 1; #1;
        chk("wdd_abort", 32'(mc_abort_o), 32'h0);
        chk("wdd_stall", 32'(stall_o), 32'h0);
        tick(); mc_done_i = 0; #1;
        chk("wdd_after_busy", 32'(mc_busy_o), 32'h0);
        chk("wdd_after_abort", 32'(mc_abort_o), 32'h0);

        // Redirect and start in the same cycle: redirect wins.
        tick(); redirect_i = 1; mc_start_i = 1; redirect_pc_i = 32'h1C00_0200; #1;
        chk("both_n_stall", 32'(stall_o), 32'h0);
        tick(); redirect_i = 0; mc_start_i = 0; #1;
        chk("both_flush", 32'(flush_o), 32'h1);
        chk("both_pc", new_pc_o, 32'h1C00_0200);
        chk("both_busy", 32'(mc_busy_o), 32'h0);
        tick(); #1;
        chk("both_after_busy", 32'(mc_busy_o), 32'h0);

        // Redirect during MC_WAIT is ignored; ID stall ORs with EX hold.
        tick(); mc_start_i = 1;
        tick(); mc_start_i = 0; redirect_i = 1; redirect_pc_i = 32'h1C00_0300; stallreq_id_i = 1; #1;
        chk("mcr_stall", 32'(stall_o), 32'h0F);
        tick(); redirect_i = 0; stallreq_id_i = 0; #1;
        chk("mcr_flush", 32'(flush_o), 32'h0);
        chk("mcr_busy", 32'(mc_busy_o), 32'h1);
        chk("mcr_pc", new_pc_o, 32'h1C00_0200);

        // Reset held 3 cycles during MC_WAIT.
        tick(); rst = 1; #1;
        chk("rstw_abort0", 32'(mc_abort_o), 32'h0);
        chk("rstw_stall0", 32'(stall_o), 32'h0);
        for (int k = 1; k <= 2; k++) begin
            tick(); #1;
            chk($sformatf("rstw%0d_busy", k), 32'(mc_busy_o), 32'h0);
            chk($sformatf("rstw%0d_abort", k), 32'(mc_abort_o), 32'h0);
            chk($sformatf("rstw%0d_pc", k), new_pc_o, 32'h0);
        end
        tick(); rst = 0; #1;
        chk("rstw_idle_busy", 32'(mc_busy_o), 32'h0);
        chk("rstw_idle_stall", 32'(stall_o), 32'h0);
        for (int k = 0; k < 8; k++) begin
            tick(); #1;
            chk($sformatf("rstw_noabort%0d", k), 32'(mc_abort_o), 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
